uart_rx_capture: RTL and testbench
==================================

# uart_rx_capture

Serial receiver that sits directly downstream of the SoC wrapper's `TX_UART` pin. It deserializes 8N1 UART frames emitted by the TEC-RISCV core and buffers the received bytes in a small FIFO. A ready/valid port hands the bytes to the verification environment (monitor/scoreboard) or to any consumer that needs the core's console output. It reports framing errors and FIFO overflow as single-cycle pulses.

## Interface

**Parameters**
- `CLKS_PER_BIT`, default 434: clock cycles per UART bit (50 MHz / 115200). Must be ≥ 4.
- `FIFO_DEPTH`, default 16: byte FIFO entries. Must be a power of two, ≥ 2.

**Ports**
- `clk`  in  1: single clock for the whole block.
- `reset`  in  1: synchronous, active-high reset.
- `rx`  in  1: serial input from `TX_UART`. Asynchronous to `clk`; idles high.
- `out_valid`  out  1: FIFO non-empty.
- `out_ready`  in  1: consumer accepts `out_data` this cycle.
- `out_data`  out  8: head-of-FIFO byte.
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1: current occupancy.
- `frame_err`  out  1: one-cycle pulse when the stop bit samples 0.
- `parity_err`  out  1: one-cycle pulse on a parity mismatch. Tied 0 when parity support is compiled out.
- `overflow`  out  1: one-cycle pulse when a good byte is dropped because the FIFO is full.

## Operation

- `rx` passes through a 2-flop synchronizer (`rx_s`); reset value 1.
- FSM states: IDLE, START, DATA, [PARITY], STOP.
  - **IDLE:** on `rx_s` = 0, go to START; bit counter = `CLKS_PER_BIT/2 - 1`.
  - **START:** at counter 0, sample `rx_s`.
    - If 0: go to DATA; bit counter reloads `CLKS_PER_BIT-1`; bit index = 0.
    - If 1: glitch; return to IDLE with no error.
  - **DATA:** at each counter 0, shift `rx_s` into the shift register, LSB first. After index 7, go to PARITY (if compiled in), otherwise STOP.
  - **PARITY:** at counter 0, compare `rx_s` with the even parity of the data bits; record a mismatch; go to STOP.
  - **STOP:** at counter 0, sample `rx_s` and return to IDLE.
    - Stop = 0: pulse `frame_err`; discard the byte.
    - Parity mismatch: pulse `parity_err`; discard the byte.
    - Otherwise: push the byte. If the FIFO is full and there is no pop that cycle, pulse `overflow` and drop the byte.
- FIFO:
  - Pop occurs when `out_valid && out_ready`.
  - Push and pop in the same cycle when full: both succeed, and the count is unchanged.
  - Push and pop in the same cycle when empty: push only (no fall-through).
- Pointers wrap modulo `FIFO_DEPTH`. `fifo_count` saturates naturally at `FIFO_DEPTH`.
- Reset at any time, including mid-frame:
  - FSM returns to IDLE.
  - FIFO is emptied.
  - All pulses go to 0.
  - A partially received frame is lost. Reception re-arms on the next falling edge of `rx_s`.
- Reset values: `out_valid` 0, `out_data` 0, `fifo_count` 0, `frame_err`/`parity_err`/`overflow` 0.

## Timing

- Synchronizer latency: 2 cycles from an `rx` edge to `rx_s`.
- Start-bit check: `CLKS_PER_BIT/2` cycles after IDLE sees `rx_s` = 0. This is the mid-bit point.
- Each subsequent sample is exactly `CLKS_PER_BIT` cycles after the previous one.
- FIFO push happens in the cycle of the stop-bit sample. `out_valid` rises the following cycle.
- Back-to-back frames are supported: a new start bit may begin immediately after the stop-bit sample.
- `out_data` is registered head data. It changes only on pop or on a push into an empty FIFO.
- Error pulses last exactly one cycle, aligned with the stop-bit sample cycle.

## Configuration

- Macro: `UART_RX_PARITY_EN`.
  - Defined: frame is 8E1. The PARITY state is present and `parity_err` is live.
  - Undefined: frame is 8N1. The PARITY state is removed and `parity_err` is constant 0.
- The port list is identical in both builds.

## Structure

- Shared package `uart_pkg`:
  - `typedef enum` for the FSM states.
  - Constant `UART_DATA_BITS` = 8.
  - Function `even_parity(byte)`.
  - The same package serves a future `uart_tx_driver` feeding `RX_UART`.
- Sub-module `uart_byte_fifo` (parameter `DEPTH`; push/pop/full/empty/count). The top holds the synchronizer, counters and FSM.

## Test plan

All scenarios use `CLKS_PER_BIT` = 8 and `FIFO_DEPTH` = 4.

1. Reset held 5 cycles with `rx` = 1 → all outputs 0. Then send 0x55, `out_ready` = 1 → `out_data` = 0x55 with `out_valid` high for 1 cycle; no error pulses.
2. Send 0xA5, 0x3C, 0xFF, 0x00 back-to-back with `out_ready` = 0 → `fifo_count` = 4. Send 0x12 → `overflow` pulse; FIFO still holds A5, 3C, FF, 00 in order.
3. Stop bit driven 0 after data 0x81 → one `frame_err` pulse; `fifo_count` unchanged.
4. 3-cycle low glitch on idle `rx` → no byte, no error; FSM back in IDLE. A following 0x7E is received correctly.
5. Reset asserted during data bit 4 of 0xC3 → FIFO empty, no pulses. Next frame 0x5A is received correctly.
6. With `UART_RX_PARITY_EN`: 0x07 sent with parity 0 (wrong) → `parity_err` pulse, byte dropped. 0x07 with parity 1 → byte 0x07 delivered.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, data width and parity helper.
// Also intended for the companion transmit driver.
package uart_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_e;

    // Even parity bit: the value that makes the total count of ones even.
    function automatic logic even_parity(input logic [UART_DATA_BITS-1:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/uart_byte_fifo.sv
// Byte FIFO with a registered head-of-queue output and an occupancy count.
// A push into an empty FIFO never falls through to a pop in the same cycle.
module uart_byte_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                        i_clk,
    input  logic                        i_reset,
    input  logic                        i_push,
    input  logic [UART_DATA_BITS-1:0]   i_data,
    input  logic                        i_pop,
    output logic [UART_DATA_BITS-1:0]   o_data,
    output logic                        o_full,
    output logic                        o_empty,
    output logic [$clog2(DEPTH):0]      o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [UART_DATA_BITS-1:0] r_mem [DEPTH];
    logic [AW-1:0]             r_wr_ptr;
    logic [AW-1:0]             r_rd_ptr;
    logic [CW-1:0]             r_count;
    logic [UART_DATA_BITS-1:0] r_head;

    logic          w_full;
    logic          w_empty;
    logic          w_do_push;
    logic          w_do_pop;
    logic [AW-1:0] w_rd_next;

    assign w_full    = (r_count == CW'(DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_do_pop  = i_pop && !w_empty;
    assign w_do_push = i_push && (!w_full || w_do_pop);
    assign w_rd_next = r_rd_ptr + AW'(1);

    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_head   <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= w_rd_next;
            end

            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + CW'(1);
            end else if (w_do_pop && !w_do_push) begin
                r_count <= r_count - CW'(1);
            end

            // When the last stored byte leaves while a new one arrives, the next
            // head is still on the input bus rather than in memory.
            if (w_do_pop) begin
                if (r_count == CW'(1)) begin
                    if (w_do_push) begin
                        r_head <= i_data;
                    end
                end else begin
                    r_head <= r_mem[w_rd_next];
                end
            end else if (w_do_push && w_empty) begin
                r_head <= i_data;
            end
        end
    end

    assign o_data  = r_head;
    assign o_full  = w_full;
    assign o_empty = w_empty;
    assign o_count = r_count;

endmodule

// File: rtl/uart_rx_capture.sv
// UART receiver capturing console bytes into a FIFO with a ready/valid output.
// Build option UART_RX_PARITY_EN selects 8E1 framing; otherwise 8N1.
module uart_rx_capture
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          rx,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [UART_DATA_BITS-1:0]     out_data,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          frame_err,
    output logic                          parity_err,
    output logic                          overflow
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(UART_DATA_BITS);
    localparam logic [CNT_W-1:0] FULL_RELOAD = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_RELOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(UART_DATA_BITS - 1);

    logic                      r_rx_meta;
    logic                      r_rx_s;
    uart_state_e               r_state;
    logic [CNT_W-1:0]          r_cnt;
    logic [IDX_W-1:0]          r_bit_idx;
    logic [UART_DATA_BITS-1:0] r_shift;
    logic                      r_frame_err;
    logic                      r_overflow;
`ifdef UART_RX_PARITY_EN
    logic                      r_par_bad;
    logic                      r_parity_err;
`endif

    logic                      w_tick;
    logic                      w_stop_sample;
    logic                      w_par_bad;
    logic                      w_good;
    logic                      w_pop;
    logic                      w_full;
    logic                      w_empty;
    logic                      w_overflow;
    logic                      w_push;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_s    <= r_rx_meta;
        end
    end

`ifdef UART_RX_PARITY_EN
    assign w_par_bad = r_par_bad;
`else
    assign w_par_bad = 1'b0;
`endif

    assign w_tick        = (r_cnt == '0);
    assign w_stop_sample = (r_state == STOP) && w_tick;
    assign w_good        = w_stop_sample && r_rx_s && !w_par_bad;
    assign w_pop         = !w_empty && out_ready;
    // A full FIFO still accepts the byte if the consumer frees a slot this cycle.
    assign w_overflow    = w_good && w_full && !w_pop;
    assign w_push        = w_good && !w_overflow;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_bit_idx   <= '0;
            r_shift     <= '0;
            r_frame_err <= 1'b0;
            r_overflow  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par_bad    <= 1'b0;
            r_parity_err <= 1'b0;
`endif
        end else begin
            r_frame_err <= 1'b0;
            r_overflow  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_parity_err <= 1'b0;
`endif
            if (r_state != IDLE && !w_tick) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end

            case (r_state)
                IDLE: begin
                    if (!r_rx_s) begin
                        r_state <= START;
                        r_cnt   <= HALF_RELOAD;
`ifdef UART_RX_PARITY_EN
                        r_par_bad <= 1'b0;
`endif
                    end
                end

                // A line that is high again at mid start bit was only a glitch.
                START: begin
                    if (w_tick) begin
                        if (!r_rx_s) begin
                            r_state   <= DATA;
                            r_cnt     <= FULL_RELOAD;
                            r_bit_idx <= '0;
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                end

                DATA: begin
                    if (w_tick) begin
                        r_shift <= {r_rx_s, r_shift[UART_DATA_BITS-1:1]};
                        r_cnt   <= FULL_RELOAD;
                        if (r_bit_idx == LAST_IDX) begin
`ifdef UART_RX_PARITY_EN
                            r_state <= PARITY;
`else
                            r_state <= STOP;
`endif
                        end else begin
                            r_bit_idx <= r_bit_idx + IDX_W'(1);
                        end
                    end
                end

`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (w_tick) begin
                        r_par_bad <= (r_rx_s != even_parity(r_shift));
                        r_cnt     <= FULL_RELOAD;
                        r_state   <= STOP;
                    end
                end
`endif

                STOP: begin
                    if (w_tick) begin
                        r_state <= IDLE;
                        if (!r_rx_s) begin
                            r_frame_err <= 1'b1;
`ifdef UART_RX_PARITY_EN
                        end else if (r_par_bad) begin
                            r_parity_err <= 1'b1;
`endif
                        end else if (w_overflow) begin
                            r_overflow <= 1'b1;
                        end
                    end
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    uart_byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (clk),
        .i_reset (reset),
        .i_push  (w_push),
        .i_data  (r_shift),
        .i_pop   (w_pop),
        .o_data  (out_data),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (fifo_count)
    );

    assign out_valid = !w_empty;
    assign frame_err = r_frame_err;
    assign overflow  = r_overflow;
`ifdef UART_RX_PARITY_EN
    assign parity_err = r_parity_err;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_capture.sv
// Directed bench for uart_rx_capture at 8 clocks per bit and a 4-entry FIFO.
// Parity scenarios are included when UART_RX_PARITY_EN is defined.
module tb_uart_rx_capture;

    localparam int CPB   = 8;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [2:0] fifo_count;
    logic       frame_err;
    logic       parity_err;
    logic       overflow;

    int checks   = 0;
    int failures = 0;

    int fe_cnt       = 0;
    int pe_cnt       = 0;
    int ov_cnt       = 0;
    int pop_cnt      = 0;
    int valid_cycles = 0;
    logic [7:0] pop_log [256];

    uart_rx_capture #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rx         (rx),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .fifo_count (fifo_count),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    // Pulses, valid cycles and handshaken bytes are tallied mid-cycle.
    always @(negedge clk) begin
        if (!reset) begin
            if (frame_err)  fe_cnt++;
            if (parity_err) pe_cnt++;
            if (overflow)   ov_cnt++;
            if (out_valid)  valid_cycles++;
            if (out_valid && out_ready) begin
                pop_log[pop_cnt % 256] = out_data;
                pop_cnt++;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        tick(CPB);
    endtask

    task automatic send_data_bits(input logic [7:0] d);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        send_data_bits(d);
`ifdef UART_RX_PARITY_EN
        send_bit(^d);
`endif
        send_bit(stop);
        rx = 1'b1;
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic send_frame_par(input logic [7:0] d, input logic par);
        send_data_bits(d);
        send_bit(par);
        send_bit(1'b1);
        rx = 1'b1;
    endtask
`endif

    task automatic test_reset;
        rx = 1'b1;
        out_ready = 1'b0;
        reset = 1'b1;
        tick(5);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL rst_valid got=%b exp=0", out_valid); end
        checks++; if (out_data !== 8'h00) begin failures++; $display("[TB] FAIL rst_data got=%h exp=00", out_data); end
        checks++; if (fifo_count !== 3'd0) begin failures++; $display("[TB] FAIL rst_count got=%0d exp=0", fifo_count); end
        checks++; if (frame_err !== 1'b0) begin failures++; $display("[TB] FAIL rst_frame_err got=%b exp=0", frame_err); end
        checks++; if (parity_err !== 1'b0) begin failures++; $display("[TB] FAIL rst_parity_err got=%b exp=0", parity_err); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("[TB] FAIL rst_overflow got=%b exp=0", overflow); end
        reset = 1'b0;
        tick(4);
    endtask

    task automatic test_single_byte;
        int p0, v0, f0, e0, o0;
        p0 = pop_cnt; v0 = valid_cycles; f0 = fe_cnt; e0 = pe_cnt; o0 = ov_cnt;
        out_ready = 1'b1;
        send_frame(8'h55, 1'b1);
        tick(4);
        checks++; if (pop_cnt - p0 !== 1) begin failures++; $display("[TB] FAIL single_pops got=%0d exp=1", pop_cnt - p0); end
        checks++; if (pop_log[p0 % 256] !== 8'h55) begin failures++; $display("[TB] FAIL single_data got=%h exp=55", pop_log[p0 % 256]); end
        checks++; if (valid_cycles - v0 !== 1) begin failures++; $display("[TB] FAIL single_valid_cycles got=%0d exp=1", valid_cycles - v0); end
        checks++; if (fe_cnt - f0 + pe_cnt - e0 + ov_cnt - o0 !== 0) begin failures++; $display("[TB] FAIL single_err_pulses got=%0d exp=0", fe_cnt - f0 + pe_cnt - e0 + ov_cnt - o0); end
        checks++; if (fifo_count !== 3'd0) begin failures++; $display("[TB] FAIL single_count got=%0d exp=0", fifo_count); end
    endtask

    task automatic test_back_to_back_overflow;
        logic [7:0] exp_b [4] = '{8'hA5, 8'h3C, 8'hFF, 8'h00};
        int p0, o0;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send_frame(exp_b[i], 1'b1);
        tick(3);
        checks++; if (fifo_count !== 3'd4) begin failures++; $display("[TB] FAIL b2b_count got=%0d exp=4", fifo_count); end
        checks++; if (out_valid !== 1'b1) begin failures++; $display("[TB] FAIL b2b_valid got=%b exp=1", out_valid); end
        checks++; if (out_data !== 8'hA5) begin failures++; $display("[TB] FAIL b2b_head got=%h exp=a5", out_data); end
        o0 = ov_cnt;
        send_frame(8'h12, 1'b1);
        tick(3);
        checks++; if (ov_cnt - o0 !== 1) begin failures++; $display("[TB] FAIL ovf_pulses got=%0d exp=1", ov_cnt - o0); end
        checks++; if (fifo_count !== 3'd4) begin failures++; $display("[TB] FAIL ovf_count got=%0d exp=4", fifo_count); end
        p0 = pop_cnt;
        out_ready = 1'b1;
        tick(6);
        out_ready = 1'b0;
        checks++; if (pop_cnt - p0 !== 4) begin failures++; $display("[TB] FAIL drain_pops got=%0d exp=4", pop_cnt - p0); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (pop_log[(p0 + i) % 256] !== exp_b[i]) begin
                failures++;
                $display("[TB] FAIL drain_byte%0d got=%h exp=%h", i, pop_log[(p0 + i) % 256], exp_b[i]);
            end
        end
        checks++; if (fifo_count !== 3'd0) begin failures++; $display("[TB] FAIL drain_count got=%0d exp=0", fifo_count); end
    endtask

    task automatic test_frame_error;
        int p0, f0, e0;
        p0 = pop_cnt; f0 = fe_cnt; e0 = pe_cnt;
        out_ready = 1'b1;
        send_frame(8'h81, 1'b0);
        tick(16);
        checks++; if (fe_cnt - f0 !== 1) begin failures++; $display("[TB] FAIL ferr_pulses got=%0d exp=1", fe_cnt - f0); end
        checks++; if (pe_cnt - e0 !== 0) begin failures++; $display("[TB] FAIL ferr_parity got=%0d exp=0", pe_cnt - e0); end
        checks++; if (pop_cnt - p0 !== 0) begin failures++; $display("[TB] FAIL ferr_pops got=%0d exp=0", pop_cnt - p0); end
        checks++; if (fifo_count !== 3'd0) begin failures++; $display("[TB] FAIL ferr_count got=%0d exp=0", fifo_count); end
    endtask

    task automatic test_glitch;
        int p0, f0, e0, o0;
        p0 = pop_cnt; f0 = fe_cnt; e0 = pe_cnt; o0 = ov_cnt;
        out_ready = 1'b1;
        rx = 1'b0;
        tick(3);
        rx = 1'b1;
        tick(20);
        checks++; if (pop_cnt - p0 !== 0) begin failures++; $display("[TB] FAIL glitch_pops got=%0d exp=0", pop_cnt - p0); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL glitch_valid got=%b exp=0", out_valid); end
        checks++; if (fe_cnt - f0 + pe_cnt - e0 + ov_cnt - o0 !== 0) begin failures++; $display("[TB] FAIL glitch_err_pulses got=%0d exp=0", fe_cnt - f0 + pe_cnt - e0 + ov_cnt - o0); end
        send_frame(8'h7E, 1'b1);
        tick(4);
        checks++; if (pop_cnt - p0 !== 1) begin failures++; $display("[TB] FAIL glitch_next_pops got=%0d exp=1", pop_cnt - p0); end
        checks++; if (pop_log[p0 % 256] !== 8'h7E) begin failures++; $display("[TB] FAIL glitch_next_data got=%h exp=7e", pop_log[p0 % 256]); end
    endtask

    task automatic test_reset_mid_frame;
        logic [7:0] c3 = 8'hC3;
        int p0, f0, e0, o0;
        out_ready = 1'b0;
        send_frame(8'h11, 1'b1);
        tick(3);
        checks++; if (fifo_count !== 3'd1) begin failures++; $display("[TB] FAIL midrst_pre_count got=%0d exp=1", fifo_count); end
        p0 = pop_cnt; f0 = fe_cnt; e0 = pe_cnt; o0 = ov_cnt;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(c3[i]);
        rx = c3[4];
        tick(4);
        reset = 1'b1;
        rx = 1'b1;
        tick(3);
        checks++; if (fifo_count !== 3'd0) begin failures++; $display("[TB] FAIL midrst_count got=%0d exp=0", fifo_count); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL midrst_valid got=%b exp=0", out_valid); end
        reset = 1'b0;
        tick(20);
        checks++; if (fifo_count !== 3'd0) begin failures++; $display("[TB] FAIL midrst_post_count got=%0d exp=0", fifo_count); end
        checks++; if (out_data !== 8'h00) begin failures++; $display("[TB] FAIL midrst_post_data got=%h exp=00", out_data); end
        checks++; if (fe_cnt - f0 + pe_cnt - e0 + ov_cnt - o0 !== 0) begin failures++; $display("[TB] FAIL midrst_err_pulses got=%0d exp=0", fe_cnt - f0 + pe_cnt - e0 + ov_cnt - o0); end
        out_ready = 1'b1;
        send_frame(8'h5A, 1'b1);
        tick(4);
        checks++; if (pop_cnt - p0 !== 1) begin failures++; $display("[TB] FAIL midrst_next_pops got=%0d exp=1", pop_cnt - p0); end
        checks++; if (pop_log[p0 % 256] !== 8'h5A) begin failures++; $display("[TB] FAIL midrst_next_data got=%h exp=5a", pop_log[p0 % 256]); end
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity;
        int p0, e0, f0;
        p0 = pop_cnt; e0 = pe_cnt; f0 = fe_cnt;
        out_ready = 1'b1;
        send_frame_par(8'h07, 1'b0);
        tick(4);
        checks++; if (pe_cnt - e0 !== 1) begin failures++; $display("[TB] FAIL par_bad_pulses got=%0d exp=1", pe_cnt - e0); end
        checks++; if (pop_cnt - p0 !== 0) begin failures++; $display("[TB] FAIL par_bad_pops got=%0d exp=0", pop_cnt - p0); end
        checks++; if (fifo_count !== 3'd0) begin failures++; $display("[TB] FAIL par_bad_count got=%0d exp=0", fifo_count); end
        send_frame_par(8'h07, 1'b1);
        tick(4);
        checks++; if (pe_cnt - e0 !== 1) begin failures++; $display("[TB] FAIL par_good_pulses got=%0d exp=1", pe_cnt - e0); end
        checks++; if (fe_cnt - f0 !== 0) begin failures++; $display("[TB] FAIL par_good_ferr got=%0d exp=0", fe_cnt - f0); end
        checks++; if (pop_cnt - p0 !== 1) begin failures++; $display("[TB] FAIL par_good_pops got=%0d exp=1", pop_cnt - p0); end
        checks++; if (pop_log[p0 % 256] !== 8'h07) begin failures++; $display("[TB] FAIL par_good_data got=%h exp=07", pop_log[p0 % 256]); end
    endtask
`endif

    initial begin
        reset = 1'b1;
        rx = 1'b1;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_single_byte();
        test_back_to_back_overflow();
        test_frame_error();
        test_glitch();
        test_reset_mid_frame();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
